// File: rtl/ahb_burst_checker.sv
// Passive AHB2 burst/protocol checker: burst FSM, expected-address tracking, registered error events.
// Optional macro AHB_CHK_STATS_EN adds burst_done_cnt_o, a count of cleanly completed bursts.
module ahb_burst_checker #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic [2:0]               HSIZE,
    input  logic                     HWRITE,
    input  logic [ADDR_WIDTH-1:0]    HADDR,
    input  logic                     HREADY,
    input  logic [1:0]               HRESP,
    input  logic                     clr_i,
    output logic                     err_valid_o,
    output logic [3:0]               err_code_o,
    output logic [ADDR_WIDTH-1:0]    err_addr_o,
    output logic [8:0]               err_sticky_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic                     burst_active_o,
    output logic [4:0]               beat_cnt_o
`ifdef AHB_CHK_STATS_EN
    ,
    output logic [15:0]              burst_done_cnt_o
`endif
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [1:0] R_OKAY   = 2'd0;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ABORT} state_t;

    function automatic logic [4:0] burst_len(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: return 5'd4;
            3'd4, 3'd5: return 5'd8;
            3'd6, 3'd7: return 5'd16;
            default:    return 5'd0;
        endcase
    endfunction

    // WRAP bursts only advance the low log2(len)+size bits; upper bits are held.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] burst,
                                                        input logic [2:0] size);
        logic [ADDR_WIDTH-1:0] sum;
        logic [ADDR_WIDTH-1:0] mask;
        logic [3:0]            wb;
        sum = addr + (ADDR_WIDTH'(1) << size);
        case (burst)
            3'd2:    wb = 4'd2;
            3'd4:    wb = 4'd3;
            3'd6:    wb = 4'd4;
            default: wb = 4'd0;
        endcase
        if (wb == 4'd0) return sum;
        mask = (ADDR_WIDTH'(1) << (wb + 4'(size))) - ADDR_WIDTH'(1);
        return (addr & ~mask) | (sum & mask);
    endfunction

    function automatic logic [3:0] first_code(input logic [8:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

    state_t                  state;
    logic [2:0]              lat_burst;
    logic [2:0]              lat_size;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   exp_addr;
    logic                    dp_idle_busy;
    logic                    prev_wait;
    logic [ADDR_WIDTH-1:0]   prev_addr;
    logic [1:0]              prev_trans;

    logic                    is_idle, is_busy, is_nonseq, is_seq;
    logic                    start, abort_entry, fixed_done;
    logic [4:0]              beat_next;
    logic [6:0]              low_mask;
    logic [8:0]              viol;
    logic                    any_viol;
    logic [ERR_CNT_WIDTH-1:0] cnt_base;

    always_comb begin
        is_idle     = (HTRANS == T_IDLE);
        is_busy     = (HTRANS == T_BUSY);
        is_nonseq   = (HTRANS == T_NONSEQ);
        is_seq      = (HTRANS == T_SEQ);
        start       = HREADY && is_nonseq && (HBURST != B_SINGLE);
        abort_entry = !HREADY && (HRESP != R_OKAY) && (state != S_ABORT);
        beat_next   = (beat_cnt_o == 5'd31) ? beat_cnt_o : beat_cnt_o + 5'd1;
        fixed_done  = (lat_burst != B_INCR) && (beat_next == burst_len(lat_burst));
        low_mask    = 7'((8'd1 << HSIZE) - 8'd1);

        viol = '0;
        if (HREADY) begin
            viol[0] = (state == S_ACTIVE) && is_seq && (HADDR != exp_addr);
            viol[1] = is_seq && (HADDR[9:0] == 10'd0);
            viol[2] = (is_seq || is_nonseq) && (|(HADDR[6:0] & low_mask));
            viol[3] = !is_idle && (HSIZE > 3'(MAX_SIZE));
            viol[4] = (state == S_IDLE) && (is_seq || is_busy);
            viol[5] = (state == S_ACTIVE) && (is_idle || is_nonseq) && (lat_burst != B_INCR);
            viol[6] = (state == S_ACTIVE) && (is_seq || is_busy) &&
                      ((HBURST != lat_burst) || (HSIZE != lat_size) || (HWRITE != lat_write));
            viol[7] = is_busy && (HBURST == B_SINGLE);
            viol[8] = dp_idle_busy && (HRESP != R_OKAY);
        end
        // Address phase must be held across an OKAY wait state.
        if (prev_wait && ((HADDR != prev_addr) || (HTRANS != prev_trans))) viol[6] = 1'b1;

        any_viol = |viol;
        cnt_base = clr_i ? '0 : err_count_o;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= S_IDLE;
            lat_burst    <= '0;
            lat_size     <= '0;
            lat_write    <= 1'b0;
            exp_addr     <= '0;
            beat_cnt_o   <= '0;
            dp_idle_busy <= 1'b0;
            prev_wait    <= 1'b0;
            prev_addr    <= '0;
            prev_trans   <= '0;
            err_valid_o  <= 1'b0;
            err_code_o   <= '0;
            err_addr_o   <= '0;
            err_sticky_o <= '0;
            err_count_o  <= '0;
        end else begin
            prev_wait  <= !HREADY && (HRESP == R_OKAY);
            prev_addr  <= HADDR;
            prev_trans <= HTRANS;
            if (HREADY) dp_idle_busy <= is_idle || is_busy;

            err_valid_o  <= any_viol;
            if (any_viol) begin
                err_code_o <= first_code(viol);
                err_addr_o <= HADDR;
            end
            err_sticky_o <= (clr_i ? 9'd0 : err_sticky_o) | viol;
            err_count_o  <= (any_viol && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;

            // A NONSEQ burst start is honoured even on the abort exit edge.
            if (abort_entry) begin
                state <= S_ABORT;
            end else if (start) begin
                state      <= S_ACTIVE;
                lat_burst  <= HBURST;
                lat_size   <= HSIZE;
                lat_write  <= HWRITE;
                beat_cnt_o <= 5'd1;
                exp_addr   <= next_addr(HADDR, HBURST, HSIZE);
            end else begin
                case (state)
                    S_ABORT: state <= S_IDLE;
                    S_ACTIVE: begin
                        if (HREADY && is_seq) begin
                            beat_cnt_o <= beat_next;
                            exp_addr   <= next_addr(HADDR, lat_burst, lat_size);
                            if (fixed_done) state <= S_IDLE;
                        end else if (HREADY && (is_idle || is_nonseq)) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign burst_active_o = (state == S_ACTIVE);

`ifdef AHB_CHK_STATS_EN
    logic burst_clean;
    logic done_inc;

    always_comb begin
        done_inc = (state == S_ACTIVE) && HREADY && burst_clean && !any_viol &&
                   ((is_seq && fixed_done) || ((is_idle || is_nonseq) && (lat_burst == B_INCR)));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            burst_clean      <= 1'b0;
            burst_done_cnt_o <= '0;
        end else begin
            if (start)
                burst_clean <= !any_viol;
            else if ((state == S_ACTIVE) && any_viol)
                burst_clean <= 1'b0;
            burst_done_cnt_o <= (clr_i ? 16'd0 : burst_done_cnt_o) + {15'd0, done_inc};
        end
    end
`endif

endmodule

// File: doc/ahb_burst_checker.md
Name: ahb_burst_checker

Overview:
- Synthesisable, parametrised AHB2 protocol checker; passive, snoops the shared bus between master and slave.
- Tracks burst state with a beat counter and an expected-address generator; flags violations as registered error events with sticky status and a saturating count.
- Generalises the bus's assertion checks to any HSIZE up to DATA_WIDTH and any ADDR_WIDTH, usable in silicon/FPGA as well as simulation.

Parameters:
- ADDR_WIDTH, 32, HADDR width (>= 11)
- DATA_WIDTH, 32, bus width in bits; MAX_SIZE = log2(DATA_WIDTH/8)
- ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  async active-low reset
- HTRANS  in  2  transfer type
- HBURST  in  3  burst type
- HSIZE  in  3  transfer size
- HWRITE  in  1  direction
- HADDR  in  ADDR_WIDTH  address
- HREADY  in  1  transfer done / address accepted
- HRESP  in  2  slave response
- clr_i  in  1  sync clear of sticky bits and counter
- err_valid_o  out  1  one-cycle error pulse
- err_code_o  out  4  code of highest-priority violation
- err_addr_o  out  ADDR_WIDTH  HADDR of offending transfer
- err_sticky_o  out  9  per-check sticky flags, bit n-1 = code n
- err_count_o  out  ERR_CNT_WIDTH  saturating violation count
- burst_active_o  out  1  inside a burst
- beat_cnt_o  out  5  beats accepted in current burst

Behaviour:
- Reset (HRESETn low, async): all outputs 0, FSM = S_IDLE, internal regs 0.
- Address phase sampled at posedge HCLK when HREADY=1; no checks on cycles with HREADY=0 except code 7.
- FSM S_IDLE: NONSEQ with HBURST!=SINGLE -> S_ACTIVE, latch HBURST/HSIZE/HWRITE, beat_cnt=1, exp_addr = next(HADDR). SINGLE stays S_IDLE.
- S_ACTIVE: accepted SEQ -> beat_cnt+1, exp_addr updated; fixed-length burst completes at beat 4/8/16 -> S_IDLE. INCR (HBURST=1) ends on accepted IDLE or NONSEQ. BUSY holds state/beat_cnt.
- S_ABORT: entered from any state when HRESP in {ERROR,RETRY,SPLIT} with HREADY=0 (first cycle); exits to S_IDLE next cycle. Early termination in S_ABORT is not a code-6 violation.
- next(): INCR types add 2^HSIZE, wraps on ADDR_WIDTH; WRAP4/8/16 increment low (log2(len)+HSIZE) bits modulo, upper bits held.
- Checks (code: condition):
  1 SEQ address != exp_addr
  2 SEQ address crosses 1KB (HADDR[9:0]==0)
  3 HADDR not aligned to 2^HSIZE
  4 HSIZE > MAX_SIZE
  5 SEQ or BUSY in S_IDLE
  6 IDLE/NONSEQ in S_ACTIVE before fixed burst complete
  7 HBURST/HSIZE/HWRITE change on SEQ/BUSY vs latched, or HADDR/HTRANS change while HREADY=0 and HRESP=OKAY
  8 BUSY with HBURST=SINGLE
  9 non-OKAY HRESP in data phase of IDLE/BUSY
- Multiple violations same cycle: all sticky bits set, err_code_o = lowest code, err_count_o += 1 (once), saturates at all-ones.
- Latency: err_valid_o/code/addr registered, asserted the cycle after the sampling edge; held 0 otherwise (code/addr keep last value).
- clr_i: clears sticky and count next edge; simultaneous new error wins (sticky set, count = 1).
- Reset mid-burst: FSM returns to S_IDLE, no error reported.

Optional Feature:
- AHB_CHK_STATS_EN: adds output burst_done_cnt_o [15:0], wrapping count of bursts completed without violation or abort, cleared by clr_i. Without macro: port absent, no counter logic.

Test Plan:
- WRAP4 word at 0x38 -> addresses 0x38,0x3C,0x30,0x34 -> no err_valid_o, beat_cnt_o reaches 4, burst_active_o drops after beat 4.
- INCR4 word at 0x3F8 then SEQ 0x3FC, 0x400 -> err_code_o=2, err_addr_o=0x400, err_count_o=1.
- SEQ halfword at 0x103 -> err_code_o=3 and sticky bits 1 and 3 set if exp mismatch; err_code_o=1 reported (lowest).
- INCR8 cut to NONSEQ after 5 beats -> code 6; same with 2-cycle ERROR at beat 5 -> no error.
- HSIZE=3 on 32-bit bus -> code 4; 300 violations -> err_count_o=255; clr_i -> 0.
- HRESETn low mid-WRAP8 -> all outputs 0 immediately; fresh NONSEQ after reset -> no code 6.
